// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI frame initiator for the single-port-RAM link
module spi_master #(
    parameter int ADDR_SIZE = 8,
    parameter int READ_LAT  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [ADDR_SIZE-1:0] cmd_data,
    output logic                 rsp_valid,
    output logic [ADDR_SIZE-1:0] rsp_data,
    output logic                 cmd_err,
    output logic                 busy,
    output logic                 SS_n,
    output logic                 MOSI,
    input  logic                 MISO
);
    localparam int FW = ADDR_SIZE + 2;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_SEL, S_SHIFT, S_WAIT, S_RECV, S_END
    } state_t;

    state_t                 state, next;
    logic [3:0]             cnt, cnt_load;
    logic [FW-1:0]          sr;
    logic [1:0]             op;
    logic [ADDR_SIZE-2:0]   cap;
    logic                   rd_addr_seen;
    logic                   accept;

    assign cmd_ready = (state == S_IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        next     = state;
        cnt_load = '0;
        case (state)
            S_IDLE:  if (accept) next = S_START;
            S_START: next = S_SEL;
            S_SEL:   next = S_SHIFT;
            S_SHIFT: if (cnt == 4'd0) next = (op == 2'b11) ? S_WAIT : S_END;
            S_WAIT:  if (cnt == 4'd0) next = S_RECV;
            S_RECV:  if (cnt == 4'd0) next = S_END;
            S_END:   next = S_IDLE;
            default: next = S_IDLE;
        endcase
        case (next)
            S_SHIFT: cnt_load = 4'(FW - 1);
            S_WAIT:  cnt_load = 4'(READ_LAT - 1);
            S_RECV:  cnt_load = 4'(ADDR_SIZE - 1);
            default: cnt_load = '0;
        endcase
    end

    // Outputs are registered, so they are computed from the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            sr           <= '0;
            op           <= '0;
            cap          <= '0;
            rd_addr_seen <= 1'b0;
            SS_n         <= 1'b1;
            MOSI         <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            cmd_err      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state     <= next;
            cnt       <= (next != state) ? cnt_load : cnt - 4'd1;
            rsp_valid <= 1'b0;
            cmd_err   <= 1'b0;
            busy      <= (next != S_IDLE);
            SS_n      <= (next == S_IDLE) || (next == S_END);

            if (accept) begin
                op      <= cmd_op;
                sr      <= {cmd_op, (cmd_op == 2'b11) ? {ADDR_SIZE{1'b0}} : cmd_data};
                cmd_err <= (cmd_op == 2'b11) && !rd_addr_seen;
            end else if (state == S_SHIFT) begin
                sr <= {sr[FW-2:0], 1'b0};
            end

            case (next)
                S_SEL:   MOSI <= sr[FW-1];
                S_SHIFT: MOSI <= (state == S_SHIFT) ? sr[FW-2] : sr[FW-1];
                default: MOSI <= 1'b0;
            endcase

            if (state == S_RECV)
                cap <= {cap[ADDR_SIZE-3:0], MISO};

            if (next == S_END && state != S_END) begin
                if (op == 2'b11) begin
                    rsp_valid    <= 1'b1;
                    rsp_data     <= {cap, MISO};
                    rd_addr_seen <= 1'b0;
                end else if (op == 2'b10) begin
                    rd_addr_seen <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - scoreboard bench for spi_master
module tb_spi_master;
    localparam int LAT_A = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       a_valid, a_ready, a_rsp_valid, a_err, a_busy, a_ssn, a_mosi, a_miso;
    logic [1:0] a_op;
    logic [7:0] a_data, a_rsp_data;
    logic       b_valid, b_ready, b_rsp_valid, b_err, b_busy, b_ssn, b_mosi, b_miso;
    logic [1:0] b_op;
    logic [7:0] b_data, b_rsp_data;

    spi_master #(.ADDR_SIZE(8), .READ_LAT(LAT_A)) u_a (
        .clk(clk), .rst(rst), .cmd_valid(a_valid), .cmd_ready(a_ready),
        .cmd_op(a_op), .cmd_data(a_data), .rsp_valid(a_rsp_valid),
        .rsp_data(a_rsp_data), .cmd_err(a_err), .busy(a_busy),
        .SS_n(a_ssn), .MOSI(a_mosi), .MISO(a_miso)
    );

    spi_master #(.ADDR_SIZE(8), .READ_LAT(3)) u_b (
        .clk(clk), .rst(rst), .cmd_valid(b_valid), .cmd_ready(b_ready),
        .cmd_op(b_op), .cmd_data(b_data), .rsp_valid(b_rsp_valid),
        .rsp_data(b_rsp_data), .cmd_err(b_err), .busy(b_busy),
        .SS_n(b_ssn), .MOSI(b_mosi), .MISO(b_miso)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         at;
        logic [7:0] data;
    } exp_t;
    exp_t qa[$];
    exp_t qb[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && a_rsp_valid) begin
            if (qa.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_a_unexpected: got rsp_data=%0h expected no response", a_rsp_data);
            end else begin
                e = qa.pop_front();
                chk("rsp_a_data", 32'(a_rsp_data), 32'(e.data));
                chk("rsp_a_cycle", cyc, e.at);
            end
        end
        if (!rst && b_rsp_valid) begin
            if (qb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_b_unexpected: got rsp_data=%0h expected no response", b_rsp_data);
            end else begin
                e = qb.pop_front();
                chk("rsp_b_data", 32'(b_rsp_data), 32'(e.data));
                chk("rsp_b_cycle", cyc, e.at);
            end
        end
    end

    task automatic wait_ready_a(output bit ok);
        int n;
        n = 0;
        while (!a_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = a_ready;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL a_accept_timeout: got cmd_ready=0 expected 1 within 200 cycles");
        end
    endtask

    // One complete frame on DUT a, checked cycle by cycle from acceptance.
    task automatic frame_a(input logic [1:0] op, input logic [7:0] data, input logic [7:0] mb,
                           input bit exp_err, input bit hold, input logic [1:0] nop,
                           input logic [7:0] ndata);
        int         endk, rk, base;
        logic [9:0] fr;
        logic       exp_mosi;
        bit         ok;
        exp_t       e;
        endk = (op == 2'b11) ? 13 + LAT_A + 8 : 13;
        rk   = 13 + LAT_A;
        fr   = {op, (op == 2'b11) ? 8'h00 : data};
        wait_ready_a(ok);
        if (!ok) return;
        a_valid = 1'b1;
        a_op    = op;
        a_data  = data;
        @(posedge clk);
        for (int k = 1; k <= endk + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                base = cyc - 1;
                if (op == 2'b11) begin
                    e.at   = base + endk;
                    e.data = mb;
                    qa.push_back(e);
                end
                if (hold) begin
                    a_op   = nop;
                    a_data = ndata;
                end else begin
                    a_valid = 1'b0;
                end
            end
            a_miso = (k >= rk && k < rk + 8) ? mb[7 - (k - rk)] : 1'b0;
            if (k == 2)
                exp_mosi = op[1];
            else if (k >= 3 && k <= 12)
                exp_mosi = fr[9 - (k - 3)];
            else
                exp_mosi = 1'b0;
            chk("a_ss_n",      32'(a_ssn),   32'(k >= endk));
            chk("a_mosi",      32'(a_mosi),  32'(exp_mosi));
            chk("a_cmd_err",   32'(a_err),   32'(k == 1 && exp_err));
            chk("a_busy",      32'(a_busy),  32'(k <= endk));
            chk("a_cmd_ready", 32'(a_ready), 32'(k > endk));
        end
    endtask

    initial begin
        bit   ok;
        int   base, n;
        exp_t e;
        logic [7:0] bm;
        rst = 1'b1;
        a_valid = 1'b0; a_op = 2'b00; a_data = 8'h00; a_miso = 1'b0;
        b_valid = 1'b0; b_op = 2'b00; b_data = 8'h00; b_miso = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ss_n",      32'(a_ssn),       32'd1);
        chk("rst_mosi",      32'(a_mosi),      32'd0);
        chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("rst_rsp_data",  32'(a_rsp_data),  32'd0);
        chk("rst_cmd_err",   32'(a_err),       32'd0);
        chk("rst_busy",      32'(a_busy),      32'd0);
        chk("rst_cmd_ready", 32'(a_ready),     32'd0);
        rst = 1'b0;
        @(negedge clk);

        // op 11 without a preceding op 10, twice; payload must be sent as zeros
        frame_a(2'b11, 8'hFF, 8'h96, 1'b1, 1'b0, 2'b00, 8'h00);
        frame_a(2'b11, 8'h00, 8'h01, 1'b1, 1'b0, 2'b00, 8'h00);
        // write address
        frame_a(2'b00, 8'h5A, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00);
        // read pair
        frame_a(2'b10, 8'h3C, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00);
        frame_a(2'b11, 8'h00, 8'hC3, 1'b0, 1'b0, 2'b00, 8'h00);
        // back-to-back writes with cmd_valid held high
        frame_a(2'b00, 8'hA5, 8'h00, 1'b0, 1'b1, 2'b01, 8'h81);
        frame_a(2'b01, 8'h81, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00);

        // reset in cycle 18 of a read after a completed op 10
        frame_a(2'b10, 8'h77, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00);
        wait_ready_a(ok);
        if (ok) begin
            a_valid = 1'b1;
            a_op    = 2'b11;
            a_data  = 8'h00;
            @(posedge clk);
            for (int k = 1; k <= 18; k++) begin
                @(negedge clk);
                if (k == 1) a_valid = 1'b0;
                a_miso = 1'b1;
                if (k == 18) rst = 1'b1;
            end
            @(negedge clk);
            chk("mid_rst_ss_n",      32'(a_ssn),       32'd1);
            chk("mid_rst_mosi",      32'(a_mosi),      32'd0);
            chk("mid_rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
            chk("mid_rst_rsp_data",  32'(a_rsp_data),  32'd0);
            chk("mid_rst_busy",      32'(a_busy),      32'd0);
            chk("mid_rst_cmd_ready", 32'(a_ready),     32'd0);
            rst    = 1'b0;
            a_miso = 1'b0;
            @(negedge clk);
            chk("post_rst_cmd_ready", 32'(a_ready), 32'd1);
        end
        // rd_addr_seen was cleared by reset, so this read flags cmd_err
        frame_a(2'b11, 8'h00, 8'h5E, 1'b1, 1'b0, 2'b00, 8'h00);

        // READ_LAT=3 instance: WAIT cycles 13-15, RECV 16-23, END 24
        bm = 8'hB7;
        n  = 0;
        while (!b_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("b_ready_before_cmd", 32'(b_ready), 32'd1);
        b_valid = 1'b1;
        b_op    = 2'b11;
        b_data  = 8'h00;
        @(posedge clk);
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k == 1) begin
                b_valid = 1'b0;
                base    = cyc - 1;
                e.at    = base + 24;
                e.data  = bm;
                qb.push_back(e);
                chk("b_cmd_err", 32'(b_err), 32'd1);
            end
            b_miso = (k >= 16 && k <= 23) ? bm[7 - (k - 16)] : 1'b0;
            chk("b_ss_n", 32'(b_ssn), 32'(k >= 24));
            chk("b_busy", 32'(b_busy), 32'(k <= 24));
        end

        repeat (5) @(negedge clk);
        chk("qa_drained", qa.size(), 32'd0);
        chk("qb_drained", qb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000 time units");
        $fatal(1);
    end
endmodule
